// File: rtl/mac16_operand_feeder_if.sv
// SRAM read bus between the operand feeder and its A/B SRAMs.
// master = feeder (issues reads), slave = SRAM side (returns data).
interface mac16_operand_feeder_if #(
    parameter int ROW_W  = 264,
    parameter int ADDR_W = 11
);
    logic              a_sram_ren;
    logic [ADDR_W-1:0] a_sram_addr;
    logic [ROW_W-1:0]  a_sram_rdata;
    logic              b_sram_ren;
    logic [ADDR_W-1:0] b_sram_addr;
    logic [ROW_W-1:0]  b_sram_rdata;

    modport master (
        output a_sram_ren, a_sram_addr,
        input  a_sram_rdata,
        output b_sram_ren, b_sram_addr,
        input  b_sram_rdata
    );

    modport slave (
        input  a_sram_ren, a_sram_addr,
        output a_sram_rdata,
        input  b_sram_ren, b_sram_addr,
        output b_sram_rdata
    );
endinterface

// File: rtl/mac16_operand_feeder.sv
// Operand sequencer for mac_16: primes a 16-row A tile, then streams
// one B word per cycle while prefetching the next A tile into a shadow.
module mac16_operand_feeder #(
    parameter int ROW_W  = 264,
    parameter int LANES  = 16,
    parameter int ADDR_W = 11,
    parameter int TILE_W = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    input  logic [TILE_W-1:0]        num_tiles,
    input  logic                     cfg_int8,
    input  logic                     cfg_int4,
    input  logic                     cfg_vsq,
    input  logic                     abort,
    mac16_operand_feeder_if.master   sram,
    output logic [LANES*ROW_W-1:0]   a_vec,
    output logic [ROW_W-1:0]         b_vec,
    output logic                     vec_valid,
    output logic                     tile_first,
    output logic                     is_int8_mode,
    output logic                     is_int4_mode,
    output logic                     is_vsq,
    output logic                     busy,
    output logic                     done
);
    localparam int CNT_W = TILE_W + 4;

    typedef enum logic [2:0] {
        S_IDLE, S_PRIME, S_STREAM, S_DRAIN, S_FLUSH
    } state_e;

    state_e                 state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [TILE_W-1:0]      n_q, n_d;
    logic                   int8_q, int8_d;
    logic                   int4_q, int4_d;
    logic                   vsq_q, vsq_d;
    logic                   busy_q, busy_d;
    logic                   done_q, done_d;
    logic                   vv_q, vv_d;
    logic                   tf_q, tf_d;
    logic [LANES*ROW_W-1:0] a_vec_q, a_vec_d;
    logic [LANES*ROW_W-1:0] shadow_q, shadow_d;
    logic [ROW_W-1:0]       b_vec_q, b_vec_d;
    logic                   a_pend_q, a_pend_d;
    logic [3:0]             a_k_q, a_k_d;
    logic                   b_pend_q, b_pend_d;
    logic [3:0]             b_j_q, b_j_d;
    logic                   a_ren, b_ren;
    logic [ADDR_W-1:0]      a_addr, b_addr;
    logic                   last_c, more_tiles;

    // Last stream cycle and whether a further tile follows this one.
    assign last_c     = ({1'b0, cnt_q} + (CNT_W+1)'(1))
                        == {1'b0, n_q, 4'b0000};
    assign more_tiles = ({1'b0, cnt_q[CNT_W-1:4]} + (TILE_W+1)'(1))
                        < {1'b0, n_q};

    // Next-state, read issue and output-register capture.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        n_d      = n_q;
        int8_d   = int8_q;
        int4_d   = int4_q;
        vsq_d    = vsq_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        vv_d     = vv_q;
        tf_d     = tf_q;
        a_vec_d  = a_vec_q;
        b_vec_d  = b_vec_q;
        shadow_d = shadow_q;
        a_ren    = 1'b0;
        b_ren    = 1'b0;
        a_addr   = '0;
        b_addr   = '0;

        // Returned A data lands in the shadow; a_vec copies the old
        // shadow so a same-edge write cannot corrupt the tile.
        if (a_pend_q)
            shadow_d[int'(a_k_q)*ROW_W +: ROW_W] = sram.a_sram_rdata;
        if (b_pend_q) begin
            b_vec_d = sram.b_sram_rdata;
            vv_d    = 1'b1;
            tf_d    = (b_j_q == 4'd0);
            if (b_j_q == 4'd0)
                a_vec_d = shadow_q;
        end

        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    n_d     = num_tiles;
                    int8_d  = cfg_int8;
                    int4_d  = cfg_int4;
                    vsq_d   = cfg_vsq;
                    busy_d  = 1'b1;
                    cnt_d   = '0;
                    state_d = (num_tiles == '0) ? S_FLUSH : S_PRIME;
                end
            end
            S_PRIME: begin
                a_ren  = 1'b1;
                a_addr = ADDR_W'(cnt_q[3:0]);
                cnt_d  = cnt_q + CNT_W'(1);
                if (cnt_q[3:0] == 4'd15) begin
                    cnt_d   = '0;
                    state_d = S_STREAM;
                end
            end
            S_STREAM: begin
                b_ren  = 1'b1;
                b_addr = cnt_q[ADDR_W-1:0];
                if (more_tiles) begin
                    a_ren  = 1'b1;
                    a_addr = cnt_q[ADDR_W-1:0] + ADDR_W'(16);
                end
                cnt_d = cnt_q + CNT_W'(1);
                if (last_c)
                    state_d = S_DRAIN;
            end
            S_DRAIN: begin
                state_d = S_FLUSH;
            end
            S_FLUSH: begin
                vv_d    = 1'b0;
                tf_d    = 1'b0;
                busy_d  = 1'b0;
                done_d  = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        a_pend_d = a_ren;
        a_k_d    = cnt_q[3:0];
        b_pend_d = b_ren;
        b_j_d    = cnt_q[3:0];

        // Kill the run; vectors hold and in-flight reads are dropped.
        if (abort) begin
            state_d  = S_IDLE;
            busy_d   = 1'b0;
            done_d   = 1'b0;
            vv_d     = 1'b0;
            tf_d     = 1'b0;
            a_vec_d  = a_vec_q;
            b_vec_d  = b_vec_q;
            shadow_d = shadow_q;
            a_pend_d = 1'b0;
            b_pend_d = 1'b0;
            int8_d   = int8_q;
            int4_d   = int4_q;
            vsq_d    = vsq_q;
        end
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            n_q      <= '0;
            int8_q   <= 1'b0;
            int4_q   <= 1'b0;
            vsq_q    <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            vv_q     <= 1'b0;
            tf_q     <= 1'b0;
            a_vec_q  <= '0;
            b_vec_q  <= '0;
            shadow_q <= '0;
            a_pend_q <= 1'b0;
            a_k_q    <= '0;
            b_pend_q <= 1'b0;
            b_j_q    <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            n_q      <= n_d;
            int8_q   <= int8_d;
            int4_q   <= int4_d;
            vsq_q    <= vsq_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            vv_q     <= vv_d;
            tf_q     <= tf_d;
            a_vec_q  <= a_vec_d;
            b_vec_q  <= b_vec_d;
            shadow_q <= shadow_d;
            a_pend_q <= a_pend_d;
            a_k_q    <= a_k_d;
            b_pend_q <= b_pend_d;
            b_j_q    <= b_j_d;
        end
    end

    assign sram.a_sram_ren  = a_ren;
    assign sram.a_sram_addr = a_addr;
    assign sram.b_sram_ren  = b_ren;
    assign sram.b_sram_addr = b_addr;
    assign a_vec        = a_vec_q;
    assign b_vec        = b_vec_q;
    assign vec_valid    = vv_q;
    assign tile_first   = tf_q;
    assign is_int8_mode = int8_q;
    assign is_int4_mode = int4_q;
    assign is_vsq       = vsq_q;
    assign busy         = busy_q;
    assign done         = done_q;
endmodule

// File: tb/tb_mac16_operand_feeder.sv
// Bench for mac16_operand_feeder: SRAM models, queue scoreboard fed
// from a tile-level reference, and a negedge monitor.
module tb_mac16_operand_feeder;
    localparam int ROW_W  = 264;
    localparam int LANES  = 16;
    localparam int ADDR_W = 11;
    localparam int DEPTH  = 2048;

    typedef struct packed {
        logic [LANES*ROW_W-1:0] a;
        logic [ROW_W-1:0]       b;
        logic                   first;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic start = 1'b0;
    logic [7:0] num_tiles = '0;
    logic cfg_int8 = 1'b0, cfg_int4 = 1'b0, cfg_vsq = 1'b0;
    logic abort = 1'b0;
    logic [LANES*ROW_W-1:0] a_vec;
    logic [ROW_W-1:0] b_vec;
    logic vec_valid, tile_first, is_int8_mode, is_int4_mode, is_vsq;
    logic busy, done;

    mac16_operand_feeder_if #(.ROW_W(ROW_W), .ADDR_W(ADDR_W)) sif ();

    mac16_operand_feeder dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .num_tiles(num_tiles), .cfg_int8(cfg_int8),
        .cfg_int4(cfg_int4), .cfg_vsq(cfg_vsq), .abort(abort),
        .sram(sif), .a_vec(a_vec), .b_vec(b_vec),
        .vec_valid(vec_valid), .tile_first(tile_first),
        .is_int8_mode(is_int8_mode), .is_int4_mode(is_int4_mode),
        .is_vsq(is_vsq), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    logic [ROW_W-1:0] a_mem [DEPTH];
    logic [ROW_W-1:0] b_mem [DEPTH];

    // Synchronous-read SRAMs: data one cycle after ren.
    always @(posedge clk) begin
        if (sif.a_sram_ren) sif.a_sram_rdata <= a_mem[sif.a_sram_addr];
        if (sif.b_sram_ren) sif.b_sram_rdata <= b_mem[sif.b_sram_addr];
    end

    exp_t sbq[$];
    int total = 0;
    int bad = 0;
    int cyc = 0;
    int e0 = 0;
    int valid_cnt, first_cnt, done_cnt, done_cyc, rise_cyc;
    int a_rd, b_rd;
    logic prev_valid = 1'b0;
    logic [2:0] exp_mode = '0;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: pop expected pair whenever a valid vector is shown.
    always @(negedge clk) begin
        if (rst_n) begin
            if (sif.a_sram_ren) a_rd++;
            if (sif.b_sram_ren) b_rd++;
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
            end
            if (vec_valid) begin
                exp_t e;
                if (!prev_valid) rise_cyc = cyc;
                valid_cnt++;
                if (tile_first) first_cnt++;
                total++;
                if (sbq.size() == 0) begin
                    bad++;
                    $display("FAIL vec_extra: cyc %0d valid with empty queue",
                             cyc);
                end else begin
                    e = sbq.pop_front();
                    if (e.b !== b_vec || e.first !== tile_first
                        || e.a !== a_vec) begin
                        bad++;
                        $display("FAIL vec cyc %0d: b got %h want %h first %b/%b",
                                 cyc, b_vec, e.b, tile_first, e.first);
                        for (int k = 0; k < LANES; k++)
                            if (a_vec[k*ROW_W +: ROW_W] !== e.a[k*ROW_W +: ROW_W])
                                $display("FAIL a_row%0d: got %h want %h", k,
                                         a_vec[k*ROW_W +: ROW_W],
                                         e.a[k*ROW_W +: ROW_W]);
                    end
                end
                total++;
                if ({is_int8_mode, is_int4_mode, is_vsq} !== exp_mode) begin
                    bad++;
                    $display("FAIL mode: got %b want %b",
                             {is_int8_mode, is_int4_mode, is_vsq}, exp_mode);
                end
            end
            prev_valid = vec_valid;
        end else begin
            prev_valid = 1'b0;
        end
    end

    task automatic chk(string nm, longint act, longint exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", nm, act, exp);
        end
    endtask

    function automatic logic [ROW_W-1:0] rnd_word();
        logic [ROW_W-1:0] w;
        w = '0;
        for (int i = 0; i < 9; i++) w = {w[ROW_W-33:0], 32'($urandom)};
        return w;
    endfunction

    // Reference: tile t pairs A words t*16..+15 with B word t*16+j.
    task automatic push_exp(int n, int limit);
        exp_t e;
        int cnt;
        cnt = 0;
        for (int t = 0; t < n; t++) begin
            for (int k = 0; k < LANES; k++)
                e.a[k*ROW_W +: ROW_W] = a_mem[(t*16 + k) % DEPTH];
            for (int j = 0; j < LANES; j++) begin
                e.b = b_mem[(t*16 + j) % DEPTH];
                e.first = (j == 0);
                if (cnt < limit) sbq.push_back(e);
                cnt++;
            end
        end
    endtask

    task automatic clr_stats();
        valid_cnt = 0; first_cnt = 0; done_cnt = 0;
        done_cyc = -1; rise_cyc = -1; a_rd = 0; b_rd = 0;
    endtask

    task automatic issue(int n, logic [2:0] mode, bit tog);
        @(negedge clk);
        clr_stats();
        num_tiles = 8'(n);
        {cfg_int8, cfg_int4, cfg_vsq} = mode;
        exp_mode = mode;
        start = 1'b1;
        @(posedge clk);
        #1;
        e0 = cyc;
        start = 1'b0;
        if (tog) {cfg_int8, cfg_int4, cfg_vsq} = ~mode;
    endtask

    task automatic run(string nm, int n, logic [2:0] mode, bit tog);
        int lim;
        push_exp(n, 16*n);
        issue(n, mode, tog);
        lim = 16*n + 60;
        for (int i = 0; i < lim && done_cnt == 0; i++) @(posedge clk);
        repeat (3) @(negedge clk);
        chk({nm, "_done_cnt"}, done_cnt, 1);
        chk({nm, "_done_cyc"}, done_cyc - e0, (n == 0) ? 1 : 18 + 16*n);
        chk({nm, "_valid_cnt"}, valid_cnt, 16*n);
        chk({nm, "_first_cnt"}, first_cnt, n);
        if (n > 0) chk({nm, "_rise"}, rise_cyc - e0, 18);
        chk({nm, "_a_reads"}, a_rd, 16*n);
        chk({nm, "_b_reads"}, b_rd, 16*n);
        chk({nm, "_q_left"}, sbq.size(), 0);
        chk({nm, "_busy"}, busy, 0);
        chk({nm, "_mode"}, {is_int8_mode, is_int4_mode, is_vsq}, mode);
        sbq.delete();
    endtask

    initial begin
        for (int i = 0; i < DEPTH; i++) begin
            a_mem[i] = rnd_word();
            b_mem[i] = rnd_word();
        end
        #12;
        @(negedge clk);
        chk("rst_valid", vec_valid, 0);
        chk("rst_busy", {busy, done, tile_first}, 0);
        chk("rst_vec", (a_vec == '0 && b_vec == '0), 1);
        chk("rst_ren", {sif.a_sram_ren, sif.b_sram_ren}, 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        run("full128", 128, 3'b000, 0);

        for (int k = 0; k < 16; k++) begin
            a_mem[k] = ROW_W'(k + 1);
            b_mem[k] = ROW_W'(32'h100 + k);
        end
        run("single", 1, 3'b001, 0);
        chk("single_row15", a_vec[15*ROW_W +: ROW_W], 16);
        chk("single_blast", b_vec, 32'h10F);

        for (int i = 0; i < 64; i++) begin
            a_mem[i] = rnd_word();
            b_mem[i] = rnd_word();
        end
        run("tile2", 2, 3'b010, 0);
        run("n0", 0, 3'b000, 0);
        chk("n0_vec", vec_valid, 0);
        run("mode", 3, 3'b100, 1);
        run("wrap130", 130, 3'b101, 0);

        // Abort during stream cycle c=20: 19 vectors seen, no done.
        push_exp(4, 19);
        issue(4, 3'b000, 0);
        repeat (36) @(posedge clk);
        #1 abort = 1'b1;
        @(posedge clk);
        #1 abort = 1'b0;
        @(negedge clk);
        chk("abort_valid", vec_valid, 0);
        chk("abort_busy", busy, 0);
        repeat (6) @(negedge clk);
        chk("abort_done", done_cnt, 0);
        chk("abort_vecs", valid_cnt, 19);
        chk("abort_q", sbq.size(), 0);
        chk("abort_ren", {sif.a_sram_ren, sif.b_sram_ren}, 0);
        sbq.delete();

        // Start together with abort in IDLE is dropped.
        @(negedge clk);
        num_tiles = 8'd3;
        start = 1'b1;
        abort = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        abort = 1'b0;
        @(negedge clk);
        chk("abort_start_busy", busy, 0);
        chk("abort_start_ren", sif.a_sram_ren, 0);

        run("post_abort", 1, 3'b011, 0);

        // Asynchronous reset mid-run.
        push_exp(2, 32);
        issue(2, 3'b111, 0);
        repeat (25) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_flags", {vec_valid, tile_first, busy, done}, 0);
        chk("arst_mode", {is_int8_mode, is_int4_mode, is_vsq}, 0);
        chk("arst_vec", (a_vec == '0 && b_vec == '0), 1);
        chk("arst_ren", {sif.a_sram_ren, sif.b_sram_ren}, 0);
        sbq.delete();
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        run("post_rst", 2, 3'b001, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
